// File: rtl/alu_pkg.sv
// Shared opcode encoding and status-flag bundle for the alu block.
// The ALU_SHIFT_EN build macro decides whether the shift opcodes execute. Without it they are reserved.
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        PASS_A = 4'b0000,
        PASS_B = 4'b0001,
        ADD    = 4'b0010,
        SUB    = 4'b0011,
        AND    = 4'b0100,
        OR     = 4'b0101,
        XOR    = 4'b0110,
        NOT    = 4'b0111,
        SHL    = 4'b1000,
        SHR    = 4'b1001,
        SAR    = 4'b1010
    } opcode_e;

    typedef struct packed {
        logic cf;
        logic of;
        logic sf;
        logic zf;
    } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath of the alu: maps (opcode, a, b) to a result, the status flags and a valid_op qualifier.
// When ALU_SHIFT_EN is defined, opcodes SHL, SHR and SAR execute. Otherwise they report valid_op=0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    result,
    output flags_t              flags,
    output logic                valid_op
);

    localparam int MSB = WIDTH - 1;

    // The extra top bit of these sums holds the carry (ADD) or the borrow (SUB).
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           cf_next;
    logic           of_next;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result   = '0;
        cf_next  = 1'b0;
        of_next  = 1'b0;
        valid_op = 1'b1;
        case (opcode_e'(opcode))
            PASS_A: result = a;
            PASS_B: result = b;
            ADD: begin
                result  = sum[MSB:0];
                cf_next = sum[WIDTH];
                of_next = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            SUB: begin
                result  = diff[MSB:0];
                cf_next = diff[WIDTH];
                of_next = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            AND: result = a & b;
            OR:  result = a | b;
            XOR: result = a ^ b;
            NOT: result = ~a;
`ifdef ALU_SHIFT_EN
            SHL: begin
                result  = {a[MSB-1:0], 1'b0};
                cf_next = a[MSB];
                of_next = a[MSB] ^ a[MSB-1];
            end
            SHR: begin
                result  = {1'b0, a[MSB:1]};
                cf_next = a[0];
            end
            SAR: begin
                result  = {a[MSB], a[MSB:1]};
                cf_next = a[0];
            end
`endif
            default: valid_op = 1'b0;
        endcase
    end

    assign flags = '{cf: cf_next, of: of_next, sf: result[MSB], zf: ~|result};

endmodule

// File: rtl/alu.sv
// Registered WIDTH-bit ALU with CF/OF/SF/ZF flags. The result bus is tri-stated by OE.
// The ALU_SHIFT_EN build macro, handled in alu_core, enables the single-bit shift opcodes.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                OE,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic [WIDTH-1:0]    ALU_OUT,
    output logic                CF,
    output logic                OF,
    output logic                SF,
    output logic                ZF
);

    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    flags_t           flags_reg;
    flags_t           flags_next;
    logic             valid_op;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .opcode  (OPCODE),
        .a       (A),
        .b       (B),
        .result  (result_next),
        .flags   (flags_next),
        .valid_op(valid_op)
    );

    // Reserved opcodes behave like EN=0, so nothing is captured.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            result_reg <= '0;
            flags_reg  <= '0;
        end else if (EN && valid_op) begin
            result_reg <= result_next;
            flags_reg  <= flags_next;
        end
    end

    assign ALU_OUT = OE ? result_reg : {WIDTH{1'bz}};
    assign CF      = flags_reg.cf;
    assign OF      = flags_reg.of;
    assign SF      = flags_reg.sf;
    assign ZF      = flags_reg.zf;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu (WIDTH=8): fixed vectors with hand-computed results and flags {CF,OF,SF,ZF}.
// Define ALU_SHIFT_EN at build time to exercise the shift opcodes.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       oe;
    logic [3:0] opcode;
    logic [7:0] a_in;
    logic [7:0] b_in;
    wire  [7:0] alu_out;
    logic       cf;
    logic       of;
    logic       sf;
    logic       zf;

    int checks = 0;
    int errors = 0;

    alu #(
        .WIDTH(8)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .EN     (en),
        .OE     (oe),
        .OPCODE (opcode),
        .A      (a_in),
        .B      (b_in),
        .ALU_OUT(alu_out),
        .CF     (cf),
        .OF     (of),
        .SF     (sf),
        .ZF     (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {ALU_OUT, CF, OF, SF, ZF} against the expected result and flags.
    task automatic chk(input string tag, input logic [7:0] exp_out, input logic [3:0] exp_flags);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {alu_out, cf, of, sf, zf};
        exp = {exp_out, exp_flags};
        checks++;
        $display("%-12s out=%h cf=%b of=%b sf=%b zf=%b", tag, alu_out, cf, of, sf, zf);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A two-state simulator resolves an undriven bus to 0, so accept z or 0.
    // The caller leaves a nonzero value in the result register.
    task automatic chk_hiz(input string tag);
        checks++;
        $display("%-12s out=%h (OE=0)", tag, alu_out);
        assert ((alu_out === 8'bzzzz_zzzz) || (alu_out === 8'h00)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=zz", tag, alu_out);
        end
    endtask

    task automatic step(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
        opcode = opc;
        a_in   = a;
        b_in   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        oe     = 1'b1;
        opcode = 4'b0010;
        a_in   = 8'd0;
        b_in   = 8'd0;
        @(posedge clk);
        #1;
        chk("reset", 8'h00, 4'b0000);
        rst_n = 1'b1;
        en    = 1'b1;

        step(4'b0010, 8'd6,   8'd5);   chk("add_6_5",     8'd11,  4'b0000);
        step(4'b0010, 8'd0,   8'd0);   chk("add_0_0",     8'd0,   4'b0001);
        step(4'b0010, 8'd150, 8'd106); chk("add_carry",   8'd0,   4'b1001);
        step(4'b0010, 8'd127, 8'd1);   chk("add_ovf",     8'd128, 4'b0110);
        step(4'b0011, 8'd60,  8'd43);  chk("sub_60_43",   8'd17,  4'b0000);
        step(4'b0011, 8'd20,  8'd20);  chk("sub_zero",    8'd0,   4'b0001);
        step(4'b0011, 8'd50,  8'd100); chk("sub_borrow",  8'd206, 4'b1010);
        step(4'b0011, 8'd127, 8'd255); chk("sub_ovf",     8'd128, 4'b1110);
        step(4'b0100, 8'd10,  8'd10);  chk("and_10_10",   8'd10,  4'b0000);
        step(4'b0100, 8'd20,  8'd10);  chk("and_zero",    8'd0,   4'b0001);
        step(4'b0101, 8'd0,   8'd0);   chk("or_zero",     8'd0,   4'b0001);
        step(4'b0101, 8'h0F,  8'h30);  chk("or_mix",      8'h3F,  4'b0000);
        step(4'b0110, 8'd255, 8'd255); chk("xor_zero",    8'd0,   4'b0001);
        step(4'b0110, 8'd128, 8'd0);   chk("xor_sign",    8'd128, 4'b0010);
        step(4'b0111, 8'd255, 8'd77);  chk("not_255",     8'd0,   4'b0001);
        step(4'b0111, 8'd127, 8'd0);   chk("not_127",     8'd128, 4'b0010);
        step(4'b0000, 8'h5A,  8'hF0);  chk("pass_a",      8'h5A,  4'b0000);
        step(4'b0001, 8'h5A,  8'hF0);  chk("pass_b",      8'hF0,  4'b0010);

        // EN low: operand changes must not reach the registers.
        en = 1'b0;
        step(4'b0010, 8'd1, 8'd1);
        step(4'b0011, 8'd3, 8'd9);     chk("en_hold",     8'hF0,  4'b0010);
        en = 1'b1;

        step(4'b1111, 8'd1, 8'd2);     chk("rsvd_1111",   8'hF0,  4'b0010);

        // The output enable acts between clock edges, with no clock delay.
        #2;
        oe = 1'b0;
        #1;
        chk_hiz("oe_off");
        oe = 1'b1;
        #1;
        chk("oe_on", 8'hF0, 4'b0010);
        oe = 1'b0;
        step(4'b0010, 8'd6, 8'd5);
        checks++;
        $display("%-12s cf=%b of=%b sf=%b zf=%b", "flags_oe0", cf, of, sf, zf);
        assert ({cf, of, sf, zf} === 4'b0000) else begin
            errors++;
            $error("FAIL flags_oe0 observed=%b expected=0000", {cf, of, sf, zf});
        end
        oe = 1'b1;
        #1;
        chk("oe_reveal", 8'd11, 4'b0000);

`ifdef ALU_SHIFT_EN
        step(4'b1000, 8'hC0, 8'hFF);   chk("shl_c0",      8'h80,  4'b1010);
        step(4'b1001, 8'h81, 8'h00);   chk("shr_81",      8'h40,  4'b1000);
        step(4'b1010, 8'h81, 8'h00);   chk("sar_81",      8'hC0,  4'b1010);
        step(4'b1000, 8'h40, 8'h00);   chk("shl_ovf",     8'h80,  4'b0110);
`else
        step(4'b1000, 8'hC0, 8'hFF);   chk("rsvd_1000",   8'd11,  4'b0000);
        step(4'b1010, 8'h81, 8'h00);   chk("rsvd_1010",   8'd11,  4'b0000);
`endif

        // Reset wins over EN while a valid opcode is presented.
        step(4'b0010, 8'd200, 8'd100); chk("pre_reset",   8'd44,  4'b1000);
        rst_n = 1'b0;
        step(4'b0010, 8'd127, 8'd1);   chk("reset_prio",  8'd0,   4'b0000);
        rst_n = 1'b1;
        step(4'b0010, 8'd127, 8'd1);   chk("after_reset", 8'd128, 4'b0110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
